// File: rtl/block_stream_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : block_stream_sched
// Brief    : Round-robin frame scheduler in front of one shared begin/end
//            nesting checker. Define SCHED_TIMEOUT_EN for the stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
module block_stream_sched #(
  parameter int N_REQ     = 4,
  parameter int FLUSH_LEN = 2,
  parameter int LEN_W     = 16,
  parameter int TMO_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [TMO_W-1:0]     tmo_limit,
  output logic                 chk_clear,
  output logic                 chk_valid,
  output logic [7:0]           chk_in,
  input  logic                 chk_result,
  output logic                 done_valid,
  output logic [2:0]           done_id,
  output logic                 done_balanced,
  output logic [LEN_W-1:0]     done_len,
  output logic                 done_timeout,
  output logic                 busy
);

  localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_FLW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [c_IDW:0]   c_NREQ       = (c_IDW+1)'(N_REQ);
  localparam logic [c_IDW-1:0] c_LAST_ID    = c_IDW'(N_REQ - 1);
  localparam logic [c_FLW-1:0] c_FLUSH_LAST = c_FLW'(FLUSH_LEN - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CLEAR  = 3'd1;
  localparam logic [2:0] c_STREAM = 3'd2;
  localparam logic [2:0] c_FLUSH  = 3'd3;
  localparam logic [2:0] c_REPORT = 3'd4;

  logic [2:0]       r_state;
  logic [c_IDW-1:0] r_rr_ptr;
  logic [c_IDW-1:0] r_grant;
  logic [LEN_W-1:0] r_len;
  logic [c_FLW-1:0] r_flush_cnt;
  logic             r_done_valid;
  logic [2:0]       r_done_id;
  logic             r_done_balanced;
  logic [LEN_W-1:0] r_done_len;

  logic             w_any;
  logic [c_IDW-1:0] w_pick;
  logic [c_IDW:0]   w_sum;
  logic             w_hs;
  logic             w_abort;
  logic [7:0]       w_byte;

  // Scan downward so the closest requester at or after r_rr_ptr wins last.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (c_IDW+1)'(k);
      if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
      if (req_valid[w_sum[c_IDW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[c_IDW-1:0];
      end
    end
  end

  assign w_hs   = (r_state == c_STREAM) && req_valid[r_grant];
  assign w_byte = req_data[{r_grant, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= c_IDLE;
      r_rr_ptr        <= '0;
      r_grant         <= '0;
      r_len           <= '0;
      r_flush_cnt     <= '0;
      r_done_valid    <= 1'b0;
      r_done_id       <= '0;
      r_done_balanced <= 1'b0;
      r_done_len      <= '0;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= c_CLEAR;
          end
        end
        c_CLEAR: begin
          r_len   <= '0;
          r_state <= c_STREAM;
        end
        c_STREAM: begin
          if (w_hs && (r_len != '1)) r_len <= r_len + 1'b1;
          if ((w_hs && req_last[r_grant]) || w_abort) begin
            r_flush_cnt <= '0;
            r_state     <= c_FLUSH;
          end
        end
        c_FLUSH: begin
          if (r_flush_cnt == c_FLUSH_LAST) r_state <= c_REPORT;
          else                             r_flush_cnt <= r_flush_cnt + 1'b1;
        end
        c_REPORT: begin
          r_done_valid    <= 1'b1;
          r_done_id       <= 3'(r_grant);
          r_done_balanced <= chk_result;
          r_done_len      <= r_len;
          r_rr_ptr        <= (r_grant == c_LAST_ID) ? '0 : r_grant + 1'b1;
          r_state         <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_aborted;
  logic             r_done_timeout;

  // The stall that reaches tmo_limit is the one that aborts the frame.
  assign w_abort = (r_state == c_STREAM) && !req_valid[r_grant] && (tmo_limit != '0) &&
                   (({1'b0, r_tmo_cnt} + 1'b1) == {1'b0, tmo_limit});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt      <= '0;
      r_aborted      <= 1'b0;
      r_done_timeout <= 1'b0;
    end else begin
      if ((r_state != c_STREAM) || w_hs) r_tmo_cnt <= '0;
      else if (r_tmo_cnt != '1)           r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (r_state == c_CLEAR)  r_aborted      <= 1'b0;
      else if (w_abort)        r_aborted      <= 1'b1;
      if (r_state == c_REPORT) r_done_timeout <= r_aborted;
    end
  end

  assign done_timeout = r_done_timeout;
`else
  wire w_unused_tmo = ^tmo_limit;
  assign w_abort      = 1'b0;
  assign done_timeout = 1'b0;
`endif

  assign req_ready     = (r_state == c_STREAM) ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_grant) : '0;
  assign chk_clear     = (r_state == c_CLEAR);
  assign chk_valid     = w_hs || (r_state == c_FLUSH);
  assign chk_in        = (r_state == c_FLUSH) ? 8'h20 : (w_hs ? w_byte : 8'h00);
  assign done_valid    = r_done_valid;
  assign done_id       = r_done_id;
  assign done_balanced = r_done_balanced;
  assign done_len      = r_done_len;
  assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire
